// File: rtl/divider_seq.sv
// divider_seq
// Sequential radix-2 restoring unsigned divider that produces one quotient bit
// per clock. It feeds the wide operand of the downstream shift-add multiplier
// and uses the same level-enable / "ok" handshake, so divider_ok can drive the
// multiplier's en directly.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           level request; held high through the operation and while the
//                result is consumed, dropped for at least one edge in between
//   dividend     M-bit unsigned dividend, sampled on the start edge only
//   divisor      D-bit unsigned divisor, sampled on the start edge only
//   quotient     M-bit registered quotient
//   remainder    D-bit registered remainder
//   divider_ok   result valid, high only in DONE
//   div_by_zero  high together with divider_ok when the latched divisor was 0
module divider_seq #(
    parameter int M = 26,
    parameter int D = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [M-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic [M-1:0] quotient,
    output logic [D-1:0] remainder,
    output logic         divider_ok,
    output logic         div_by_zero
);

    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [M-1:0]  work;
    logic [D-1:0]  divisor_r;
    logic [D-1:0]  partial_rem;
    logic [CW-1:0] count;
    logic          dbz_r;

    logic [D:0]    trial;
    logic          q_bit;
    logic [D-1:0]  next_rem;
    logic          last_iter;

    // One restoring step: bring the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The subtraction can be
    // done in D bits because whenever it is taken the true difference is
    // smaller than the divisor, so the carry-out bit is always zero.
    always_comb begin
        trial     = {partial_rem, work[M-1]};
        q_bit     = (trial >= {1'b0, divisor_r});
        next_rem  = q_bit ? (trial[D-1:0] - divisor_r) : trial[D-1:0];
        last_iter = (count == CW'(M - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A zero divisor skips CALC entirely; dropping en in
    // CALC aborts, and takes priority over completion on the final edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (en) begin
                    next_state = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (!en) begin
                    next_state = IDLE;
                end else if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!en) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output flags are decoded from the registered state, so they clear on
    // the same edge that leaves DONE without touching quotient/remainder.
    always_comb begin
        divider_ok  = (state == DONE);
        div_by_zero = (state == DONE) && dbz_r;
    end

    // Datapath: operand capture on the start edge, one shift/subtract per
    // CALC edge, and result load only on the completion edge (or the start
    // edge for divide-by-zero), so quotient/remainder are stable while ok.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work        <= '0;
            divisor_r   <= '0;
            partial_rem <= '0;
            count       <= '0;
            dbz_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        work        <= dividend;
                        divisor_r   <= divisor;
                        partial_rem <= '0;
                        count       <= '0;
                        dbz_r       <= (divisor == '0);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                        end
                    end
                end
                CALC: begin
                    if (en) begin
                        work        <= {work[M-2:0], q_bit};
                        partial_rem <= next_rem;
                        count       <= count + CW'(1);
                        if (last_iter) begin
                            quotient  <= {work[M-2:0], q_bit};
                            remainder <= next_rem;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq
// Scoreboard bench for divider_seq. The driver pushes the hand-computed result
// and the cycle it must appear on; a monitor pops and compares whenever
// divider_ok rises. Abort, hold, release and asynchronous reset behaviour are
// checked directly by the driver.
module tb_divider_seq;

    localparam int M = 26;
    localparam int D = 13;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [M-1:0] dividend = '0;
    logic [D-1:0] divisor = '0;
    logic [M-1:0] quotient;
    logic [D-1:0] remainder;
    logic         divider_ok;
    logic         div_by_zero;

    typedef struct packed {
        logic [M-1:0] q;
        logic [D-1:0] r;
        logic         dbz;
        int           at_cycle;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_ok = 1'b0;

    divider_seq #(.M(M), .D(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .divider_ok  (divider_ok),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock and a cycle counter used to check latency.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: on every rising divider_ok pop the next expected result and
    // compare values and the cycle it arrived on.
    always @(negedge clk) begin
        exp_t e;
        if (divider_ok && !prev_ok) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_ok: divider_ok rose with q=%0d r=%0d dbz=%0b, no result was expected",
                         quotient, remainder, div_by_zero);
            end else begin
                e = sb.pop_front();
                if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz || cyc != e.at_cycle) begin
                    errors++;
                    $display("[TB] FAIL result: got q=%0d r=%0d dbz=%0b cycle=%0d, expected q=%0d r=%0d dbz=%0b cycle=%0d",
                             quotient, remainder, div_by_zero, cyc, e.q, e.r, e.dbz, e.at_cycle);
                end
            end
        end
        prev_ok = divider_ok;
    end

    // Compare the full output set against expected values.
    task automatic checkOutput(input string name, input logic [M-1:0] eq, input logic [D-1:0] er,
                               input logic eok, input logic edbz);
        checks++;
        if (quotient !== eq || remainder !== er || divider_ok !== eok || div_by_zero !== edbz) begin
            errors++;
            $display("[TB] FAIL %s: got q=%0d r=%0d ok=%0b dbz=%0b, expected q=%0d r=%0d ok=%0b dbz=%0b",
                     name, quotient, remainder, divider_ok, div_by_zero, eq, er, eok, edbz);
        end
    endtask

    // Run one full operation: start, scramble operands after the start edge,
    // wait (bounded) for ok, check the hold, then release and check clearing.
    task automatic applyStimulus(input logic [M-1:0] a, input logic [D-1:0] b,
                                 input logic [M-1:0] eq, input logic [D-1:0] er,
                                 input logic edbz, input string name);
        int   lat;
        int   waited;
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        en       = 1'b1;
        lat      = edbz ? 0 : M;
        e.q        = eq;
        e.r        = er;
        e.dbz      = edbz;
        e.at_cycle = cyc + 1 + lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        dividend = ~a;
        divisor  = b ^ 13'h1555;
        waited = 0;
        while (!divider_ok && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!divider_ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: divider_ok=%0b after %0d cycles, required 1", name, divider_ok, waited);
        end
        repeat (3) @(negedge clk);
        checkOutput({name, "_hold"}, eq, er, 1'b1, edbz);
        en = 1'b0;
        @(negedge clk);
        checkOutput({name, "_release"}, eq, er, 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        checkOutput("reset", '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(26'd1000000,  13'd3,    26'd333333,   13'd1, 1'b0, "normal_1000000_3");
        applyStimulus(26'd67108863, 13'd8191, 26'd8193,     13'd0, 1'b0, "max_div_8191");
        applyStimulus(26'd67108863, 13'd1,    26'd67108863, 13'd0, 1'b0, "max_div_1");
        applyStimulus(26'd5,        13'd7,    26'd0,        13'd5, 1'b0, "small_5_7");
        applyStimulus(26'd12345,    13'd0,    26'h3FFFFFF,  13'd0, 1'b1, "div_by_zero");

        // Abort mid-calculation: no result may appear and outputs hold.
        @(negedge clk);
        dividend = 26'd1000000;
        divisor  = 13'd3;
        en       = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("abort_hold", 26'h3FFFFFF, '0, 1'b0, 1'b0);

        // Restart and assert reset between clock edges mid-calculation.
        en = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", '0, '0, 1'b0, 1'b0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(26'd100, 13'd9, 26'd11, 13'd1, 1'b0, "after_reset_100_9");

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover: %0d results never seen, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
